// File: rtl/fetch_state_unit.sv
// fetch_state_unit
// State registers of the multicycle MIPS core: PC, IR, MDR and ALUOut,
// plus a fetch counter and a sticky PC-alignment error flag.
//
// Ports:
//   CLK, RST         clock; synchronous active-high reset
//   IRWE             IR load enable (also counts fetches)
//   PCWE, Branch     unconditional / Zero-qualified PC write enables
//   Zero             ALU zero flag
//   PCSel[1:0]       next-PC source: 00 ALUResult, 01 ALUOut, 10 jump, 11 hold
//   IDSel            memory address select: 0 = PC, 1 = ALUOut
//   ALUResult        current-cycle ALU result
//   MemRData         unified memory read data
//   MemAddr          unified memory address (combinational)
//   PC, Instr        program counter, instruction register
//   Opcode, Funct, Rs, Rt, Rd, SignImm   decode fields from IR
//   ALUOut, MDR      registered ALU result / memory data
//   FetchCount       IR loads since reset (wraps silently)
//   AlignErr         sticky: PC written with bits [1:0] != 00
module fetch_state_unit #(
    parameter int DWL  = 32,
    parameter int OPW  = 6,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IRWE,
    input  logic            PCWE,
    input  logic            Branch,
    input  logic            Zero,
    input  logic [1:0]      PCSel,
    input  logic            IDSel,
    input  logic [DWL-1:0]  ALUResult,
    input  logic [DWL-1:0]  MemRData,
    output logic [DWL-1:0]  MemAddr,
    output logic [DWL-1:0]  PC,
    output logic [DWL-1:0]  Instr,
    output logic [OPW-1:0]  Opcode,
    output logic [OPW-1:0]  Funct,
    output logic [4:0]      Rs,
    output logic [4:0]      Rt,
    output logic [4:0]      Rd,
    output logic [DWL-1:0]  SignImm,
    output logic [DWL-1:0]  ALUOut,
    output logic [DWL-1:0]  MDR,
    output logic [CNTW-1:0] FetchCount,
    output logic            AlignErr
);

    logic           pc_en;
    logic           pc_load;
    logic [DWL-1:0] next_pc;

    assign pc_en = PCWE | (Branch & Zero);

    always_comb begin
        next_pc = PC;
        case (PCSel)
            2'b00:   next_pc = ALUResult;
            2'b01:   next_pc = ALUOut;
            2'b10:   next_pc = {PC[31:28], Instr[25:0], 2'b00};
            default: next_pc = PC;
        endcase
    end

    // PCSel = 11 is reserved: PC holds even with a write enable.
    assign pc_load = pc_en && (PCSel != 2'b11);

    // An X enable evaluates false in the if conditions below, so it never updates state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC         <= '0;
            Instr      <= '0;
            MDR        <= '0;
            ALUOut     <= '0;
            FetchCount <= '0;
            AlignErr   <= 1'b0;
        end else begin
            MDR    <= MemRData;
            ALUOut <= ALUResult;
            if (IRWE) begin
                Instr      <= MemRData;
                FetchCount <= FetchCount + 1'b1;
            end
            if (pc_load) begin
                PC <= next_pc;
                if (next_pc[1:0] != 2'b00)
                    AlignErr <= 1'b1;
            end
        end
    end

    // Written as if/else so an X select falls through to PC.
    always_comb begin
        if (IDSel)
            MemAddr = ALUOut;
        else
            MemAddr = PC;
    end

    assign Opcode  = Instr[31:26];
    assign Funct   = Instr[5:0];
    assign Rs      = Instr[25:21];
    assign Rt      = Instr[20:16];
    assign Rd      = Instr[15:11];
    assign SignImm = {{(DWL-16){Instr[15]}}, Instr[15:0]};

endmodule

// File: tb/tb_fetch_state_unit.sv
module tb_fetch_state_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        IRWE = 1'b0, PCWE = 1'b0, Branch = 1'b0, Zero = 1'b0, IDSel = 1'b0;
    logic [1:0]  PCSel = 2'b00;
    logic [31:0] ALUResult = '0, MemRData = '0;
    logic [31:0] MemAddr, PC, Instr, SignImm, ALUOut, MDR;
    logic [5:0]  Opcode, Funct;
    logic [4:0]  Rs, Rt, Rd;
    logic [15:0] FetchCount;
    logic        AlignErr;

    int total = 0;
    int bad   = 0;

    fetch_state_unit #(.DWL(32), .OPW(6), .CNTW(16)) dut (
        .CLK(CLK), .RST(RST), .IRWE(IRWE), .PCWE(PCWE), .Branch(Branch),
        .Zero(Zero), .PCSel(PCSel), .IDSel(IDSel), .ALUResult(ALUResult),
        .MemRData(MemRData), .MemAddr(MemAddr), .PC(PC), .Instr(Instr),
        .Opcode(Opcode), .Funct(Funct), .Rs(Rs), .Rt(Rt), .Rd(Rd),
        .SignImm(SignImm), .ALUOut(ALUOut), .MDR(MDR),
        .FetchCount(FetchCount), .AlignErr(AlignErr)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IRWE = 1'b0; PCWE = 1'b0; Branch = 1'b0; Zero = 1'b0;
        PCSel = 2'b00; IDSel = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; IRWE = 1'b1; PCWE = 1'b1; PCSel = 2'b00;
        MemRData = 32'hDEADBEEF; ALUResult = 32'h00001234;
        step(); step();
        total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
        total++; if (Instr !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=%h", Instr, 32'h0); end
        total++; if (FetchCount !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=%h", FetchCount, 16'h0); end
        total++; if (AlignErr !== 1'b0) begin bad++; $display("FAIL reset_align got=%b exp=0", AlignErr); end
        total++; if (MemAddr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", MemAddr, 32'h0); end
        total++; if (Opcode !== 6'b0) begin bad++; $display("FAIL reset_opcode got=%b exp=000000", Opcode); end
        total++; if (MDR !== 32'h0 || ALUOut !== 32'h0) begin bad++; $display("FAIL reset_mdr_aluout got=%h/%h exp=0/0", MDR, ALUOut); end
        RST = 1'b0; idle();
    endtask

    task automatic test_fetch();
        MemRData = 32'h8C820004; ALUResult = 32'h4;
        IRWE = 1'b1; PCWE = 1'b1; PCSel = 2'b00; IDSel = 1'b0;
        #1;
        total++; if (MemAddr !== 32'h0) begin bad++; $display("FAIL fetch_addr_pre got=%h exp=%h", MemAddr, 32'h0); end
        step();
        idle();
        total++; if (Instr !== 32'h8C820004) begin bad++; $display("FAIL fetch_ir got=%h exp=%h", Instr, 32'h8C820004); end
        total++; if (Opcode !== 6'b100011) begin bad++; $display("FAIL fetch_opcode got=%b exp=100011", Opcode); end
        total++; if (Rs !== 5'd4 || Rt !== 5'd2 || Rd !== 5'd0) begin bad++; $display("FAIL fetch_regs got=%0d/%0d/%0d exp=4/2/0", Rs, Rt, Rd); end
        total++; if (SignImm !== 32'h4 || Funct !== 6'd4) begin bad++; $display("FAIL fetch_imm got=%h/%h exp=4/4", SignImm, Funct); end
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL fetch_pc got=%h exp=%h", PC, 32'h4); end
        total++; if (FetchCount !== 16'd1) begin bad++; $display("FAIL fetch_cnt got=%0d exp=1", FetchCount); end
        total++; if (MDR !== 32'h8C820004 || ALUOut !== 32'h4) begin bad++; $display("FAIL fetch_mdr_aluout got=%h/%h exp=8c820004/4", MDR, ALUOut); end
    endtask

    task automatic test_decode();
        // beq $4,$5,-8 : negative immediate, IR load without PC write
        MemRData = 32'h1085FFF8; IRWE = 1'b1;
        step();
        idle();
        total++; if (SignImm !== 32'hFFFFFFF8) begin bad++; $display("FAIL decode_signimm got=%h exp=%h", SignImm, 32'hFFFFFFF8); end
        total++; if (Opcode !== 6'b000100 || Rt !== 5'd5) begin bad++; $display("FAIL decode_fields got=%b/%0d exp=000100/5", Opcode, Rt); end
        total++; if (PC !== 32'h4 || FetchCount !== 16'd2) begin bad++; $display("FAIL decode_pc_cnt got=%h/%0d exp=4/2", PC, FetchCount); end
        // IR holds and decode ignores MemRData when IRWE = 0
        MemRData = 32'hFC000000;
        step();
        total++; if (Opcode !== 6'b000100 || Instr !== 32'h1085FFF8) begin bad++; $display("FAIL decode_hold got=%h exp=%h", Instr, 32'h1085FFF8); end
        total++; if (MDR !== 32'hFC000000) begin bad++; $display("FAIL decode_mdr got=%h exp=%h", MDR, 32'hFC000000); end
    endtask

    task automatic test_branch();
        ALUResult = 32'h20; step();
        Branch = 1'b1; PCSel = 2'b01; Zero = 1'b0; ALUResult = 32'h99;
        step();
        total++; if (PC !== 32'h4) begin bad++; $display("FAIL branch_not_taken got=%h exp=%h", PC, 32'h4); end
        total++; if (ALUOut !== 32'h99) begin bad++; $display("FAIL branch_aluout got=%h exp=%h", ALUOut, 32'h99); end
        idle(); ALUResult = 32'h20; step();
        Branch = 1'b1; PCSel = 2'b01; Zero = 1'b1; ALUResult = 32'h99;
        step();
        total++; if (PC !== 32'h20) begin bad++; $display("FAIL branch_taken got=%h exp=%h", PC, 32'h20); end
        // PCWE with Branch writes regardless of Zero
        idle(); ALUResult = 32'h30; step();
        PCWE = 1'b1; Branch = 1'b1; Zero = 1'b0; PCSel = 2'b01; ALUResult = 32'h99;
        step();
        idle();
        total++; if (PC !== 32'h30) begin bad++; $display("FAIL branch_pcwe got=%h exp=%h", PC, 32'h30); end
    endtask

    task automatic test_jump();
        PCWE = 1'b1; PCSel = 2'b00; ALUResult = 32'h40000010; step();
        idle(); IRWE = 1'b1; MemRData = 32'h08000100; step();
        idle(); PCWE = 1'b1; PCSel = 2'b10; ALUResult = 32'h0;
        step();
        idle();
        total++; if (PC !== 32'h40000400) begin bad++; $display("FAIL jump_pc got=%h exp=%h", PC, 32'h40000400); end
        total++; if (FetchCount !== 16'd3) begin bad++; $display("FAIL jump_cnt got=%0d exp=3", FetchCount); end
    endtask

    task automatic test_addr_hold();
        ALUResult = 32'h100; step();
        IDSel = 1'b1; #1;
        total++; if (MemAddr !== 32'h100) begin bad++; $display("FAIL addr_aluout got=%h exp=%h", MemAddr, 32'h100); end
        IDSel = 1'b0; #1;
        total++; if (MemAddr !== 32'h40000400) begin bad++; $display("FAIL addr_pc got=%h exp=%h", MemAddr, 32'h40000400); end
        PCWE = 1'b1; PCSel = 2'b11; ALUResult = 32'h7;
        step();
        idle();
        total++; if (PC !== 32'h40000400) begin bad++; $display("FAIL hold_pc got=%h exp=%h", PC, 32'h40000400); end
        total++; if (AlignErr !== 1'b0) begin bad++; $display("FAIL hold_align got=%b exp=0", AlignErr); end
    endtask

    task automatic test_align();
        PCWE = 1'b1; PCSel = 2'b00; ALUResult = 32'h6;
        step();
        total++; if (PC !== 32'h6 || AlignErr !== 1'b1) begin bad++; $display("FAIL align_set got=%h/%b exp=6/1", PC, AlignErr); end
        ALUResult = 32'h8;
        step();
        idle();
        total++; if (PC !== 32'h8 || AlignErr !== 1'b1) begin bad++; $display("FAIL align_sticky got=%h/%b exp=8/1", PC, AlignErr); end
        // reset mid-instruction discards every pending update
        RST = 1'b1; IRWE = 1'b1; PCWE = 1'b1; ALUResult = 32'h13; MemRData = 32'h12345678;
        step();
        RST = 1'b0; idle();
        total++; if (AlignErr !== 1'b0 || PC !== 32'h0) begin bad++; $display("FAIL align_reset got=%b/%h exp=0/0", AlignErr, PC); end
        total++; if (Instr !== 32'h0 || FetchCount !== 16'd0) begin bad++; $display("FAIL rst_priority got=%h/%0d exp=0/0", Instr, FetchCount); end
    endtask

    task automatic test_wrap();
        IRWE = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        total++; if (FetchCount !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h exp=%h", FetchCount, 16'hFFFF); end
        step();
        idle();
        total++; if (FetchCount !== 16'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=%h", FetchCount, 16'h0); end
    endtask

    initial begin
        #2;
        test_reset();
        test_fetch();
        test_decode();
        test_branch();
        test_jump();
        test_addr_hold();
        test_align();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_state_unit.md
# fetch_state_unit

Architectural and non-architectural state registers of the multicycle MIPS core: program counter (PC), instruction register (IR), memory data register (MDR) and ALU output register (ALUOut). It sits directly upstream of the main controller: it feeds the controller its Opcode from the IR. It consumes the controller's IRWE, PCWE, Branch, PCSel and IDSel strobes to sequence fetch, branch and jump, and it drives the unified instruction/data memory address. It also keeps a fetch counter and a sticky PC-alignment error flag for debug.

## Interface
- DWL, 32, datapath width; PC, IR, MDR, ALUOut width.
- OPW, 6, opcode/funct field width.
- CNTW, 16, fetch counter width.

- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- IRWE  in  1  IR load enable.
- PCWE  in  1  unconditional PC write enable.
- Branch  in  1  conditional PC write enable, qualified by Zero.
- Zero  in  1  ALU zero flag.
- PCSel  in  2  next-PC source select.
- IDSel  in  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUResult  in  DWL  current-cycle ALU result.
- MemRData  in  DWL  unified memory read data.
- MemAddr  out  DWL  unified memory address.
- PC  out  DWL  program counter.
- Instr  out  DWL  IR contents.
- Opcode  out  OPW  Instr[31:26]; goes to the main controller.
- Funct  out  OPW  Instr[5:0].
- Rs, Rt, Rd  out  5 each  Instr[25:21], [20:16], [15:11].
- SignImm  out  DWL  Instr[15:0] sign-extended.
- ALUOut  out  DWL  registered ALU result.
- MDR  out  DWL  registered memory read data.
- FetchCount  out  CNTW  number of IR loads since reset.
- AlignErr  out  1  sticky flag for a misaligned PC write.

## Operation
- PCEn = PCWE | (Branch & Zero).
- Next PC by PCSel:
  - 00: ALUResult.
  - 01: ALUOut.
  - 10: jump target {PC[31:28], Instr[25:0], 2'b00}.
  - 11: reserved. PC holds even when PCEn = 1.
- PC loads next PC when PCEn = 1 and PCSel != 11.
- IR loads MemRData when IRWE = 1. Otherwise IR holds.
- MDR loads MemRData every cycle, unconditionally.
- ALUOut loads ALUResult every cycle, unconditionally.
- MemAddr = IDSel ? ALUOut : PC. This path is combinational. An X or 0 on IDSel selects PC; implement the select as a 2:1 mux with IDSel == 1 choosing ALUOut.
- FetchCount increments by 1 on every cycle with IRWE = 1. It wraps from 2^CNTW-1 to 0 with no flag.
- AlignErr sets when the PC is actually written with a next-PC value whose bits [1:0] != 00. It stays set until RST.
- Decode outputs (Opcode, Funct, Rs, Rt, Rd, SignImm) are combinational from IR only. They never come from MemRData directly.
- X on any enable input (IRWE, PCWE, Branch) is treated as 0 for state updates. Controller outputs are X only in non-writing states.

## Timing
- Reset values, all applied on the first rising edge with RST = 1:
  - PC = 0, IR = 0, MDR = 0, ALUOut = 0, FetchCount = 0, AlignErr = 0.
  - Hence Opcode = 000000 and MemAddr = 0.
- RST has priority over every enable. Asserting RST mid-instruction discards all pending updates on that edge.
- Fetch cycle (IRWE = 1, PCWE = 1, PCSel = 00, IDSel = 0):
  - IR captures the word at the old PC.
  - PC captures ALUResult (PC+4) on the same edge.
  - The new Opcode is visible one cycle later, during decode.
- Branch cycle: the PC update, when Zero = 1, is visible the next cycle. The target comes from ALUOut, which was loaded on the previous edge.
- Jump cycle: the target uses the current IR and the current PC[31:28], i.e. values from before the edge.
- ALUOut and MDR have latency 1: the value presented at edge N is readable from edge N onward, until edge N+1.
- The MemAddr to MemRData path is combinational through memory. The IR/MDR capture at the next edge.
- Simultaneous PCWE = 1 and Branch = 1 write the PC regardless of Zero.

## Test plan
- Reset: drive RST = 1 for 2 cycles with IRWE = 1, PCWE = 1 -> PC = 0, Instr = 0, FetchCount = 0, AlignErr = 0, MemAddr = 0.
- Fetch: PC = 0x0, MemRData = 0x8C820004, ALUResult = 0x4, IRWE = PCWE = 1 -> next cycle Instr = 0x8C820004, Opcode = 100011, Rs = 4, Rt = 2, SignImm = 0x00000004, PC = 0x4, FetchCount = 1.
- Branch: ALUOut preloaded with 0x20, Branch = 1, PCSel = 01:
  - with Zero = 0 -> PC unchanged.
  - repeat with Zero = 1 -> PC = 0x20.
- Jump: PC = 0x40000010, Instr = 0x08000100, PCWE = 1, PCSel = 10 -> PC = 0x40000400.
- Address select and hold: ALUOut = 0x100, IDSel = 1 -> MemAddr = 0x100. Then PCWE = 1, PCSel = 11 -> PC unchanged, AlignErr = 0.
- Alignment and wrap:
  - PCWE = 1, PCSel = 00, ALUResult = 0x6 -> PC = 0x6 and AlignErr = 1 until RST.
  - 65536 IRWE pulses with CNTW = 16 -> FetchCount returns to 0.
